ring_buffer_fifo: RTL and testbench

//  Parametrised single-clock ring buffer; next generation of the UART byte buffer.
//  - Full DEPTH capacity: no sacrificed slot, using an extra pointer wrap bit.
//  - Adds occupancy count, almost-full/almost-empty levels, sticky overflow/underflow flags.
//  - Sits between the UART RX/TX shifters and the CPU-side register file.

---
 rtl/ring_buffer_pkg.sv | 22 ++
 rtl/ring_buffer_mem.sv | 37 +++
 rtl/ring_buffer_fifo.sv | 153 +++++++++++++++
 tb/tb_ring_buffer_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ring_buffer_pkg.sv
// Shared types and sizing helpers for the ring buffer FIFO.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package ring_buffer_pkg;

    // Width of the statistics counters exposed on debug.
    localparam int STATS_W = 16;

    // Pointer width: index bits plus one wrap bit, so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Occupancy status bundle derived from the pointer difference.
    typedef struct packed {
        logic full;
        logic empty;
        logic almostFull;
        logic almostEmpty;
    } flags_t;

endpackage

// File: rtl/ring_buffer_mem.sv
// DEPTH x WIDTH register array with one write port and one registered read port.
// Latency: read data appears 1 clock after i_rd_en; write lands on the same edge.
// Backpressure: none; the read register holds its value while i_rd_en is low.
module ring_buffer_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_dat;

    // Storage write; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    // Registered read; sees the pre-write word when both ports hit one address.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/ring_buffer_fifo.sv
// Single-clock ring buffer using all DEPTH slots (wrap-bit pointers); optional stats via RING_BUFFER_STATS_EN.
// Latency: read data and acks are registered, 1 clock after the request.
// Backpressure: writes to a full buffer are dropped (overflow), reads of an empty one rejected (underflow).
module ring_buffer_fifo
    import ring_buffer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int CW       = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             writeEnable,
    input  logic [WIDTH-1:0] dataWrite,
    output logic             writeAck,
    input  logic             readEnable,
    output logic             dataReadAck,
    output logic [WIDTH-1:0] dataRead,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almostFull,
    output logic             almostEmpty,
    output logic             overflow,
    output logic             underflow,
    input  logic             clearFlags,
    output logic [31:0]      debug,
    output logic [31:0]      debug2
);

    localparam int AW = CW - 1;

    logic [CW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_rd_ptr;
    logic [CW-1:0]    w_count;
    flags_t           w_flags;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_rd_rej;
    logic             w_wr_rej;
    logic             r_wack;
    logic             r_rack;
    logic             r_rd_seen;
    logic             r_ovf;
    logic             r_udf;
    logic [WIDTH-1:0] w_mem_rdata;

    // Wrap bit makes the modulo-2*DEPTH difference the exact occupancy 0..DEPTH.
    assign w_count = r_wr_ptr - r_rd_ptr;

    // Status flags decoded from occupancy.
    always_comb begin
        w_flags             = '0;
        w_flags.full        = (w_count == CW'(DEPTH));
        w_flags.empty       = (w_count == '0);
        w_flags.almostFull  = (w_count >= CW'(AF_LEVEL));
        w_flags.almostEmpty = (w_count <= CW'(AE_LEVEL));
    end

    // A read frees a slot this cycle, so a full buffer can still take a write alongside it.
    // An empty buffer never bypasses the write into the read.
    assign w_rd_acc = readEnable && !w_flags.empty;
    assign w_wr_acc = writeEnable && (!w_flags.full || w_rd_acc);
    assign w_rd_rej = readEnable && !w_rd_acc;
    assign w_wr_rej = writeEnable && !w_wr_acc;

    ring_buffer_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_dat  (dataWrite),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_dat  (w_mem_rdata)
    );

    // Pointer advance on accepted transfers; natural CW-bit wrap gives modulo 2*DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // One-cycle acks; r_rd_seen gates the un-reset memory read register until the first real read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wack    <= 1'b0;
            r_rack    <= 1'b0;
            r_rd_seen <= 1'b0;
        end else begin
            r_wack <= w_wr_acc;
            r_rack <= w_rd_acc;
            if (w_rd_acc) r_rd_seen <= 1'b1;
        end
    end

    // Sticky fault flags; a fault in the same cycle as clearFlags keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_wr_rej)        r_ovf <= 1'b1;
            else if (clearFlags) r_ovf <= 1'b0;
            if (w_rd_rej)        r_udf <= 1'b1;
            else if (clearFlags) r_udf <= 1'b0;
        end
    end

    assign writeAck    = r_wack;
    assign dataReadAck = r_rack;
    assign dataRead    = r_rd_seen ? w_mem_rdata : '0;
    assign count       = w_count;
    assign full        = w_flags.full;
    assign empty       = w_flags.empty;
    assign almostFull  = w_flags.almostFull;
    assign almostEmpty = w_flags.almostEmpty;
    assign overflow    = r_ovf;
    assign underflow   = r_udf;

`ifdef RING_BUFFER_STATS_EN
    logic [STATS_W-1:0] r_drop_cnt;
    logic [STATS_W-1:0] r_high_water;

    // Saturating drop counter and peak occupancy tracker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt   <= '0;
            r_high_water <= '0;
        end else begin
            if (w_wr_rej && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
            if (STATS_W'(w_count) > r_high_water) r_high_water <= STATS_W'(w_count);
        end
    end

    assign debug  = {r_drop_cnt, r_high_water};
    assign debug2 = {STATS_W'(r_wr_ptr), STATS_W'(r_rd_ptr)};
`else
    assign debug  = 32'h0;
    assign debug2 = 32'h0;
`endif

endmodule

// File: tb/tb_ring_buffer_fifo.sv
// Directed bench for ring_buffer_fifo at WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
// Latency: inputs change 1 time unit after posedge; outputs checked 1 unit after the next posedge.
// Backpressure: exercised through full-buffer writes and empty-buffer reads.
module tb_ring_buffer_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        writeEnable;
    logic [7:0]  dataWrite;
    logic        writeAck;
    logic        readEnable;
    logic        dataReadAck;
    logic [7:0]  dataRead;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        almostFull;
    logic        almostEmpty;
    logic        overflow;
    logic        underflow;
    logic        clearFlags;
    logic [31:0] debug;
    logic [31:0] debug2;

    int checks   = 0;
    int failures = 0;

    ring_buffer_fifo #(
        .WIDTH    (8),
        .DEPTH    (4),
        .AF_LEVEL (3),
        .AE_LEVEL (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .writeEnable (writeEnable),
        .dataWrite   (dataWrite),
        .writeAck    (writeAck),
        .readEnable  (readEnable),
        .dataReadAck (dataReadAck),
        .dataRead    (dataRead),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almostFull  (almostFull),
        .almostEmpty (almostEmpty),
        .overflow    (overflow),
        .underflow   (underflow),
        .clearFlags  (clearFlags),
        .debug       (debug),
        .debug2      (debug2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [7:0] d, input logic re, input logic cf);
        writeEnable = we;
        dataWrite   = d;
        readEnable  = re;
        clearFlags  = cf;
    endtask

    initial begin
        logic [7:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

        // Reset state
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_aempty", 32'(almostEmpty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wack", 32'(writeAck), 32'd0);
        chk("rst_rack", 32'(dataReadAck), 32'd0);
        chk("rst_dread", 32'(dataRead), 32'd0);
        chk("rst_flags", 32'({overflow, underflow}), 32'd0);

        // Test 1: fill
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill[i], 1'b0, 1'b0);
            cyc();
            chk($sformatf("t1_wack%0d", i), 32'(writeAck), 32'd1);
            chk($sformatf("t1_count%0d", i), 32'(count), 32'(i + 1));
            chk($sformatf("t1_afull%0d", i), 32'(almostFull), (i >= 2) ? 32'd1 : 32'd0);
            chk($sformatf("t1_full%0d", i), 32'(full), (i == 3) ? 32'd1 : 32'd0);
        end

        // Test 2: overflow, then drain in order
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        cyc();
        chk("t2_wack", 32'(writeAck), 32'd0);
        chk("t2_ovf", 32'(overflow), 32'd1);
        chk("t2_count", 32'(count), 32'd4);
`ifdef RING_BUFFER_STATS_EN
        chk("t2_stats", debug, 32'h0001_0004);
`else
        chk("t2_debug", debug, 32'h0);
        chk("t2_debug2", debug2, 32'h0);
`endif
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            cyc();
            chk($sformatf("t2_rack%0d", i), 32'(dataReadAck), 32'd1);
            chk($sformatf("t2_dread%0d", i), 32'(dataRead), 32'(fill[i]));
            chk($sformatf("t2_count%0d", i), 32'(count), 32'(3 - i));
        end
        chk("t2_empty", 32'(empty), 32'd1);

        // Test 3: underflow; fault beats clear; then clear
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        cyc();
        chk("t3_rack", 32'(dataReadAck), 32'd0);
        chk("t3_hold", 32'(dataRead), 32'h44);
        chk("t3_udf", 32'(underflow), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        cyc();
        chk("t3_udf_wins", 32'(underflow), 32'd1);
        chk("t3_ovf_clr", 32'(overflow), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        cyc();
        chk("t3_udf_clr", 32'(underflow), 32'd0);

        // Test 4: simultaneous read/write when full, then when empty
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hC1 + 8'(i), 1'b0, 1'b0);
            cyc();
        end
        chk("t4_full", 32'(full), 32'd1);
        drive(1'b1, 8'h66, 1'b1, 1'b0);
        cyc();
        chk("t4_wack", 32'(writeAck), 32'd1);
        chk("t4_rack", 32'(dataReadAck), 32'd1);
        chk("t4_dread", 32'(dataRead), 32'hC1);
        chk("t4_count", 32'(count), 32'd4);
        chk("t4_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            cyc();
            chk($sformatf("t4_drain%0d", i), 32'(dataRead), (i == 3) ? 32'h66 : 32'(8'hC2 + 8'(i)));
        end
        drive(1'b1, 8'h67, 1'b1, 1'b0);
        cyc();
        chk("t4e_wack", 32'(writeAck), 32'd1);
        chk("t4e_rack", 32'(dataReadAck), 32'd0);
        chk("t4e_count", 32'(count), 32'd1);
        chk("t4e_udf", 32'(underflow), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        cyc();
        chk("t4e_dread", 32'(dataRead), 32'h67);
        chk("t4e_count0", 32'(count), 32'd0);
        chk("t4e_udf_clr", 32'(underflow), 32'd0);

        // Test 5: ten pairs across pointer wrap
        drive(1'b1, 8'hA0, 1'b0, 1'b0);
        cyc();
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0);
            cyc();
            chk($sformatf("t5_dread%0d", i), 32'(dataRead), 32'(8'hA0 + 8'(i - 1)));
            chk($sformatf("t5_count%0d", i), 32'(count), 32'd1);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        cyc();
        chk("t5_last", 32'(dataRead), 32'hA9);
        chk("t5_count_end", 32'(count), 32'd0);

        // Test 6: asynchronous reset mid-burst
        drive(1'b1, 8'hB1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 8'hB2, 1'b0, 1'b0);
        cyc();
        chk("t6_count2", 32'(count), 32'd2);
        drive(1'b1, 8'hB3, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_wack", 32'(writeAck), 32'd0);
        chk("t6_dread", 32'(dataRead), 32'd0);
        chk("t6_rack", 32'(dataReadAck), 32'd0);
        chk("t6_debug", debug, 32'd0);
        cyc();
        reset = 1'b0;
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        cyc();
        chk("t6_wack77", 32'(writeAck), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        cyc();
        chk("t6_rack77", 32'(dataReadAck), 32'd1);
        chk("t6_dread77", 32'(dataRead), 32'h77);
        chk("t6_empty", 32'(empty), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
